grey_incr_sched: RTL and testbench
==================================

# grey_incr_sched

Sequencer and round-robin arbiter that shares one 6-bit Gray-code counter among NREQ requesters. Each requester asks for a burst of increments. The block grants one requester at a time and drives the counter's `rst`/`incr` inputs with paced single-cycle pulses, giving the level-sensitive counter time to settle. It keeps a binary shadow count and checks every returned Gray value against the expected encoding, latching a sticky error on mismatch. It sits between client logic and the Gray counter instance in the user area.

## Interface
Parameters:
- `NREQ`, 4: number of requesters (2..8).
- `GAP`, 3: idle cycles with `cnt_incr` low after each pulse before checking (≥1).

Ports:
- Power pins through the common power-port macro, as on every user block.
- `clk`  in  1  single clock; all outputs registered on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  NREQ  level request per requester.
- `req_cnt`  in  4*NREQ  increments requested; slice i is `req_cnt[4i+3:4i]`, range 0..15.
- `gnt`  out  NREQ  one-hot grant, held for the whole burst.
- `done`  out  NREQ  one-cycle pulse on the granted bit when its burst completes.
- `cnt_rst`  out  1  drives the counter's `rst`.
- `cnt_incr`  out  1  drives the counter's `incr`.
- `cnt_grey`  in  6  Gray value returned by the counter.
- `shadow`  out  6  binary count of increments issued since the last counter reset.
- `err`  out  1  sticky mismatch flag.

## Operation
- States: INIT, IDLE, PULSE, SETTLE, CHECK, DONE.
- Reset (`rst`=1):
  - State is INIT with an INIT cycle counter of 0.
  - `gnt`=0, `done`=0, `cnt_incr`=0, `cnt_rst`=1, `shadow`=0, `err`=0.
  - Round-robin pointer = NREQ-1, so requester 0 has top priority first.
- INIT: `cnt_rst`=1 for 2 cycles after `rst` falls, then go to CHECK with remaining=0 and no grant, which verifies `cnt_grey`==0.
- IDLE, when any `req` bit is set:
  - Grant the first set bit searching upward from pointer+1, wrapping.
  - Latch its `req_cnt` slice into remaining.
  - If remaining is nonzero go to PULSE, else go to DONE.
- PULSE: `cnt_incr`=1 for exactly one cycle; `shadow` += 1 mod 64; remaining -= 1; go to SETTLE.
- SETTLE: `cnt_incr`=0 for GAP cycles; go to CHECK.
- CHECK (one cycle):
  - Compare `cnt_grey` with `shadow ^ (shadow >> 1)`; on mismatch set `err`.
  - If remaining is nonzero go to PULSE; else go to DONE, or to IDLE when leaving INIT.
- DONE: pulse `done[i]`; drop `gnt` at the end of this cycle; pointer = i; go to IDLE.
- `err` clears only on `rst`; arbitration and pacing continue after an error.
- Deasserting `req[i]` mid-burst has no effect: the burst always completes.
- `req_cnt` is sampled only at grant; later changes are ignored.
- Wrap-around: `shadow` 63→0 is legal, and the expected Gray value goes 6'b100000→6'b000000.
- `cnt_rst` is never asserted outside reset/INIT. `cnt_incr` and `cnt_rst` are never high together.
- `rst` mid-burst:
  - Aborts immediately: `gnt`/`done`/`cnt_incr` go to 0 the next cycle.
  - No `done` is issued for the aborted burst.
  - Counter and shadow are re-zeroed through INIT.

## Timing
- With request at cycle t in IDLE:
  - Grant registered at the edge ending t, so `gnt` and `cnt_incr` are high in cycle t+1.
  - Each increment takes GAP+2 cycles (PULSE + SETTLE + CHECK).
  - For burst N≥1, `done` is high in cycle t+1+N·(GAP+2); `gnt` is high in cycles t+1 .. t+1+N·(GAP+2).
  - For N=0, `gnt` and `done` are both high in cycle t+1 only.
- Back-to-back grants: IDLE occupies one cycle after DONE, so the next grant is visible two cycles after the previous `done`.
- From `rst` falling:
  - `cnt_rst` is high for 2 more cycles.
  - The CHECK that verifies `cnt_grey`==0 follows.
  - The first grant can appear no earlier than cycle 5 after `rst` falls.

## Test plan
- Reset then single request: `req`=4'b0001, `req_cnt[3:0]`=3, GAP=3, counter model ideal. Required: `gnt`=0001 for 16 cycles; 3 single-cycle `cnt_incr` pulses 5 cycles apart; `shadow`=3; `cnt_grey`=6'b000010; one `done[0]` pulse; `err`=0.
- Round robin: all four `req` held with `req_cnt`=1 each. Required: grants go 0,1,2,3,0 in order; each `gnt` lasts 6 cycles; a gap of one IDLE cycle between grants.
- Wrap-around: preload 63 increments via requester 2, then 1 more. Required: `shadow` reads 63 then 0; `cnt_grey` reads 6'b100000 then 6'b000000; `err`=0.
- Fault injection: force `cnt_grey` bit 3 high in the CHECK cycle of the 2nd increment. Required: `err` rises the next cycle and stays high through further bursts until `rst`.
- Zero count and abort:
  - `req_cnt`=0 gives `gnt` and `done` in the same single cycle with no `cnt_incr`.
  - Asserting `rst` during SETTLE of a 5-count burst gives no `done`, `cnt_rst` high for `rst`+2 cycles, and `shadow`=0.

Source files
------------

// File: rtl/grey_incr_sched.sv
// -----------------------------------------------------------------------------
// grey_incr_sched
//
// Shares one 6-bit Gray-code counter among NREQ requesters. A round-robin
// arbiter grants one requester at a time. For each granted burst the block
// drives paced single-cycle increment pulses into the counter. After each
// pulse it waits GAP cycles so the level-sensitive counter can settle. It then
// checks the returned Gray value against a binary shadow count.
//
// Parameters
//   NREQ      number of requesters (2..8)
//   GAP       idle cycles after each increment pulse before the check (>=1)
//
// Ports
//   vccd1/vssd1  power pins (only when USE_POWER_PINS is defined)
//   clk          single clock; every output is a flop on its rising edge
//   rst          synchronous, active-high reset
//   req          level request per requester
//   req_cnt      4-bit increment count per requester, slice i = [4i+3:4i]
//   gnt          one-hot grant, held for the whole burst
//   done         one-cycle pulse on the granted bit when its burst completes
//   cnt_rst      drives the counter's rst (reset/INIT only)
//   cnt_incr     drives the counter's incr (one cycle per increment)
//   cnt_grey     Gray value returned by the counter
//   shadow       binary count of increments since the last counter reset
//   err          sticky Gray mismatch flag, cleared only by rst
// -----------------------------------------------------------------------------

// Protocol checker: invariants of the counter drive and the grant outputs.
module grey_incr_sched_chk #(
    parameter int NREQ = 4
) (
    input logic            clk,
    input logic            rst,
    input logic [NREQ-1:0] gnt,
    input logic [NREQ-1:0] done,
    input logic            cnt_rst,
    input logic            cnt_incr
);

    // The counter must never see reset and increment in the same cycle.
    a_rst_incr_excl : assert property (@(posedge clk) !(cnt_rst && cnt_incr));

    // At most one requester holds the grant.
    a_gnt_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));

    // A completion pulse only appears on the bit that holds the grant.
    a_done_in_gnt : assert property (@(posedge clk) disable iff (rst)
                                     ((done & ~gnt) == {NREQ{1'b0}}));

endmodule

module grey_incr_sched #(
    parameter int NREQ = 4,
    parameter int GAP  = 3
) (
`ifdef USE_POWER_PINS
    inout  wire                 vccd1,
    inout  wire                 vssd1,
`endif
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [4*NREQ-1:0]   req_cnt,
    output logic [NREQ-1:0]     gnt,
    output logic [NREQ-1:0]     done,
    output logic                cnt_rst,
    output logic                cnt_incr,
    input  logic [5:0]          cnt_grey,
    output logic [5:0]          shadow,
    output logic                err
);

    localparam int PW = $clog2(NREQ);
    localparam int SW = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_IDLE   = 3'd1,
        ST_PULSE  = 3'd2,
        ST_SETTLE = 3'd3,
        ST_CHECK  = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    // Binary-to-Gray encoding of the expected counter value.
    function automatic logic [5:0] gray6(input logic [5:0] b);
        return b ^ (b >> 1);
    endfunction

    // Round-robin search: first set request strictly after ptr, wrapping.
    // Returns {found, index}.
    function automatic logic [PW:0] rr_pick(input logic [NREQ-1:0] r,
                                            input logic [PW-1:0]   ptr);
        logic          found;
        logic [PW-1:0] sel;
        int            idx;
        found = 1'b0;
        sel   = ptr;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && r[idx[PW-1:0]]) begin
                found = 1'b1;
                sel   = idx[PW-1:0];
            end else begin
                found = found;
            end
        end
        return {found, sel};
    endfunction

    // Extract the 4-bit request count of requester sel.
    function automatic logic [3:0] slice_of(input logic [4*NREQ-1:0] rc,
                                            input logic [PW-1:0]     sel);
        logic [3:0] s;
        s = 4'd0;
        for (int i = 0; i < NREQ; i++) begin
            if (sel == PW'(i)) begin
                s = rc[4*i +: 4];
            end else begin
                s = s;
            end
        end
        return s;
    endfunction

    state_t          state_q,     state_d;
    logic            init_cnt_q,  init_cnt_d;
    logic            from_init_q, from_init_d;
    logic [PW-1:0]   ptr_q,       ptr_d;
    logic [PW-1:0]   gidx_q,      gidx_d;
    logic [3:0]      rem_q,       rem_d;
    logic [SW-1:0]   settle_q,    settle_d;
    logic [NREQ-1:0] gnt_q,       gnt_d;
    logic [NREQ-1:0] done_q,      done_d;
    logic            cnt_rst_q,   cnt_rst_d;
    logic            cnt_incr_q,  cnt_incr_d;
    logic [5:0]      shadow_q,    shadow_d;
    logic            err_q,       err_d;

    logic [PW:0]     pick_s;
    logic            pick_found_s;
    logic [PW-1:0]   pick_idx_s;
    logic [3:0]      pick_cnt_s;
    logic [NREQ-1:0] pick_onehot_s;

    // Arbitration candidate for the IDLE state.
    always_comb begin
        pick_s        = rr_pick(req, ptr_q);
        pick_found_s  = pick_s[PW];
        pick_idx_s    = pick_s[PW-1:0];
        pick_cnt_s    = slice_of(req_cnt, pick_idx_s);
        pick_onehot_s = {{(NREQ-1){1'b0}}, 1'b1} << pick_idx_s;
    end

    // Next-state and next-output logic of the sequencer.
    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        from_init_d = from_init_q;
        ptr_d       = ptr_q;
        gidx_d      = gidx_q;
        rem_d       = rem_q;
        settle_d    = settle_q;
        gnt_d       = gnt_q;
        done_d      = {NREQ{1'b0}};
        cnt_rst_d   = 1'b0;
        cnt_incr_d  = 1'b0;
        shadow_d    = shadow_q;
        err_d       = err_q;

        case (state_q)
            ST_INIT: begin
                // Hold the counter in reset for two cycles, then verify it
                // reads zero through a grant-less CHECK.
                shadow_d = 6'd0;
                gnt_d    = {NREQ{1'b0}};
                if (init_cnt_q) begin
                    state_d     = ST_CHECK;
                    rem_d       = 4'd0;
                    from_init_d = 1'b1;
                    cnt_rst_d   = 1'b0;
                end else begin
                    init_cnt_d = 1'b1;
                    cnt_rst_d  = 1'b1;
                end
            end

            ST_IDLE: begin
                if (pick_found_s) begin
                    gidx_d = pick_idx_s;
                    gnt_d  = pick_onehot_s;
                    rem_d  = pick_cnt_s;
                    if (pick_cnt_s != 4'd0) begin
                        state_d    = ST_PULSE;
                        cnt_incr_d = 1'b1;
                    end else begin
                        // Empty burst: grant and completion in one cycle.
                        state_d = ST_DONE;
                        done_d  = pick_onehot_s;
                    end
                end else begin
                    gnt_d = {NREQ{1'b0}};
                end
            end

            ST_PULSE: begin
                // cnt_incr is high in this cycle; account for it now.
                shadow_d = shadow_q + 6'd1;
                rem_d    = rem_q - 4'd1;
                settle_d = {SW{1'b0}};
                state_d  = ST_SETTLE;
            end

            ST_SETTLE: begin
                if (settle_q == SW'(GAP - 1)) begin
                    state_d = ST_CHECK;
                end else begin
                    settle_d = settle_q + {{(SW-1){1'b0}}, 1'b1};
                end
            end

            ST_CHECK: begin
                if (cnt_grey != gray6(shadow_q)) begin
                    err_d = 1'b1;
                end else begin
                    err_d = err_q;
                end
                if (rem_q != 4'd0) begin
                    state_d    = ST_PULSE;
                    cnt_incr_d = 1'b1;
                end else if (from_init_q) begin
                    state_d     = ST_IDLE;
                    from_init_d = 1'b0;
                end else begin
                    state_d = ST_DONE;
                    done_d  = gnt_q;
                end
            end

            ST_DONE: begin
                // done is high this cycle; release the grant at its end and
                // make the finished requester lowest priority next.
                gnt_d   = {NREQ{1'b0}};
                ptr_d   = gidx_q;
                state_d = ST_IDLE;
            end

            default: begin
                // Unreachable encoding: recover through a full re-init.
                state_d     = ST_INIT;
                init_cnt_d  = 1'b0;
                from_init_d = 1'b0;
                gnt_d       = {NREQ{1'b0}};
                cnt_rst_d   = 1'b1;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= 1'b0;
            from_init_q <= 1'b0;
            ptr_q       <= PW'(NREQ - 1);
            gidx_q      <= {PW{1'b0}};
            rem_q       <= 4'd0;
            settle_q    <= {SW{1'b0}};
            gnt_q       <= {NREQ{1'b0}};
            done_q      <= {NREQ{1'b0}};
            cnt_rst_q   <= 1'b1;
            cnt_incr_q  <= 1'b0;
            shadow_q    <= 6'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            from_init_q <= from_init_d;
            ptr_q       <= ptr_d;
            gidx_q      <= gidx_d;
            rem_q       <= rem_d;
            settle_q    <= settle_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            cnt_rst_q   <= cnt_rst_d;
            cnt_incr_q  <= cnt_incr_d;
            shadow_q    <= shadow_d;
            err_q       <= err_d;
        end
    end

    assign gnt      = gnt_q;
    assign done     = done_q;
    assign cnt_rst  = cnt_rst_q;
    assign cnt_incr = cnt_incr_q;
    assign shadow   = shadow_q;
    assign err      = err_q;

    grey_incr_sched_chk #(
        .NREQ (NREQ)
    ) u_chk (
        .clk      (clk),
        .rst      (rst),
        .gnt      (gnt_q),
        .done     (done_q),
        .cnt_rst  (cnt_rst_q),
        .cnt_incr (cnt_incr_q)
    );

endmodule

// File: tb/tb_grey_incr_sched.sv
// Directed bench for grey_incr_sched with an ideal Gray counter model.
module tb_grey_incr_sched;

    localparam int NREQ = 4;
    localparam int GAP  = 3;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] req_cnt;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        cnt_rst;
    logic        cnt_incr;
    logic [5:0]  cnt_grey;
    logic [5:0]  shadow;
    logic        err;

    logic [5:0]  ctr = 6'd0;
    logic [5:0]  fault_mask = 6'd0;

    int n_cmp = 0;
    int n_bad = 0;
    int step  = 0;

`ifdef USE_POWER_PINS
    wire vccd1 = 1'b1;
    wire vssd1 = 1'b0;
`endif

    grey_incr_sched #(
        .NREQ (NREQ),
        .GAP  (GAP)
    ) dut (
`ifdef USE_POWER_PINS
        .vccd1    (vccd1),
        .vssd1    (vssd1),
`endif
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_cnt  (req_cnt),
        .gnt      (gnt),
        .done     (done),
        .cnt_rst  (cnt_rst),
        .cnt_incr (cnt_incr),
        .cnt_grey (cnt_grey),
        .shadow   (shadow),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ideal external counter: reset/increment sampled on the clock edge.
    always @(posedge clk) begin
        if (cnt_rst) ctr <= 6'd0;
        else if (cnt_incr) ctr <= ctr + 6'd1;
    end
    assign cnt_grey = (ctr ^ (ctr >> 1)) ^ fault_mask;

    typedef struct {
        logic [3:0]  req;
        logic [15:0] rc;
        int          idx;
        int          n;
        logic [5:0]  sh;
        logic [5:0]  gr;
    } vec_t;

    vec_t tbl [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (step %0d): got 0x%0h, expected 0x%0h", name, step, act, exp);
        end
    endtask

    // Reset, check reset values and INIT timing; returns in the first IDLE cycle.
    task automatic do_reset();
        rst = 1'b1;
        req = 4'd0;
        tick();
        tick();
        chk("rst_gnt",      32'(gnt),      32'd0);
        chk("rst_done",     32'(done),     32'd0);
        chk("rst_cnt_incr", 32'(cnt_incr), 32'd0);
        chk("rst_cnt_rst",  32'(cnt_rst),  32'd1);
        chk("rst_shadow",   32'(shadow),   32'd0);
        chk("rst_err",      32'(err),      32'd0);
        rst = 1'b0;
        chk("init_cnt_rst_c1", 32'(cnt_rst), 32'd1);
        tick();
        chk("init_cnt_rst_c2", 32'(cnt_rst), 32'd1);
        tick();
        chk("init_cnt_rst_off", 32'(cnt_rst), 32'd0);
        chk("init_gnt",         32'(gnt),     32'd0);
        tick();
        chk("init_check_err", 32'(err), 32'd0);
    endtask

    // One burst from IDLE: request now, drop request after grant, measure it.
    task automatic do_burst(input logic [3:0] r, input logic [15:0] rc, input int idx,
                            input int n, input logic [5:0] esh, input logic [5:0] egr,
                            input logic eerr);
        int len, incr, dones, done_at, first_incr, last_incr;
        bit spacing_ok, stable, done_ok;
        logic [3:0] g0;
        step++;
        req     = r;
        req_cnt = rc;
        tick();
        chk("gnt_select", 32'(gnt), 32'(1 << idx));
        req     = 4'd0;
        req_cnt = ~rc;
        g0 = gnt;
        len = 0; incr = 0; dones = 0; done_at = -1; first_incr = -1; last_incr = -100;
        spacing_ok = 1'b1; stable = 1'b1; done_ok = 1'b1;
        while (gnt != 4'd0 && len < 400) begin
            if (gnt != g0) stable = 1'b0;
            if (cnt_incr) begin
                if (incr == 0) first_incr = len;
                else if (len - last_incr != GAP + 2) spacing_ok = 1'b0;
                last_incr = len;
                incr++;
            end
            if (done != 4'd0) begin
                dones++;
                done_at = len;
                if (done != g0) done_ok = 1'b0;
            end
            len++;
            tick();
        end
        chk("gnt_len",     32'(len),        32'((n == 0) ? 1 : 1 + n * (GAP + 2)));
        chk("gnt_stable",  32'(stable),     32'd1);
        chk("incr_count",  32'(incr),       32'(n));
        chk("incr_first",  32'(first_incr), 32'((n == 0) ? -1 : 0));
        chk("incr_space",  32'(spacing_ok), 32'd1);
        chk("done_count",  32'(dones),      32'd1);
        chk("done_last",   32'(done_at),    32'(len - 1));
        chk("done_bit",    32'(done_ok),    32'd1);
        chk("shadow",      32'(shadow),     32'(esh));
        chk("cnt_grey",    32'(cnt_grey),   32'(egr));
        chk("err",         32'(err),        32'(eerr));
    endtask

    initial begin
        int z, len, crst_hi, done_seen;
        bit gnt_quiet;

        // idx / n / shadow / Gray are hand-derived from the arbitration order
        // (pointer starts at 3) and the running increment total.
        tbl[0] = '{4'b0001, 16'h0003, 0,  3, 6'd3,  6'b000010};
        tbl[1] = '{4'b1111, 16'h4321, 1,  2, 6'd5,  6'b000111};
        tbl[2] = '{4'b1001, 16'h0000, 3,  0, 6'd5,  6'b000111};
        tbl[3] = '{4'b0101, 16'h0F07, 0,  7, 6'd12, 6'b001010};
        tbl[4] = '{4'b0110, 16'h00A0, 1, 10, 6'd22, 6'b011101};
        tbl[5] = '{4'b0110, 16'h0F00, 2, 15, 6'd37, 6'b110111};

        rst = 1'b1; req = 4'd0; req_cnt = 16'd0;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            do_burst(tbl[i].req, tbl[i].rc, tbl[i].idx, tbl[i].n, tbl[i].sh, tbl[i].gr, 1'b0);
        end

        // Round robin from reset: all requesters held, one increment each.
        step = 100;
        do_reset();
        req = 4'hF; req_cnt = 16'h1111;
        for (int g = 0; g < 5; g++) begin
            z = 0;
            while (gnt == 4'd0 && z < 20) begin z++; tick(); end
            chk("rr_gap",   32'(z),   32'd1);
            chk("rr_order", 32'(gnt), 32'(1 << (g % 4)));
            if (g == 4) req = 4'd0;
            len = 0;
            while (gnt != 4'd0 && len < 50) begin len++; tick(); end
            chk("rr_len", 32'(len), 32'd6);
        end
        chk("rr_shadow", 32'(shadow),   32'd5);
        chk("rr_grey",   32'(cnt_grey), 32'b000111);

        // Wrap-around through requester 2: 15,30,45,60,63 then 0.
        step = 200;
        do_reset();
        do_burst(4'b0100, 16'h0F00, 2, 15, 6'd15, 6'b001000, 1'b0);
        do_burst(4'b0100, 16'h0F00, 2, 15, 6'd30, 6'b010001, 1'b0);
        do_burst(4'b0100, 16'h0F00, 2, 15, 6'd45, 6'b111011, 1'b0);
        do_burst(4'b0100, 16'h0F00, 2, 15, 6'd60, 6'b100010, 1'b0);
        do_burst(4'b0100, 16'h0300, 2,  3, 6'd63, 6'b100000, 1'b0);
        do_burst(4'b0100, 16'h0100, 2,  1, 6'd0,  6'b000000, 1'b0);

        // Fault: corrupt bit 3 in the CHECK cycle of the 2nd increment.
        step = 300;
        do_reset();
        req = 4'b0001; req_cnt = 16'h0003;
        tick();
        req = 4'd0;
        repeat (9) tick();
        fault_mask = 6'b001000;
        chk("fault_err_before", 32'(err), 32'd0);
        tick();
        fault_mask = 6'd0;
        chk("fault_err_rise", 32'(err), 32'd1);
        len = 0;
        while (gnt != 4'd0 && len < 50) begin len++; tick(); end
        chk("fault_err_hold", 32'(err), 32'd1);
        do_burst(4'b0010, 16'h0020, 1, 2, 6'd5, 6'b000111, 1'b1);
        step = 310;
        do_reset();

        // Abort: rst during SETTLE of a 5-count burst.
        step = 400;
        req = 4'b0001; req_cnt = 16'h0005;
        tick();
        chk("abort_gnt", 32'(gnt), 32'b0001);
        req = 4'd0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("abort_gnt0",   32'(gnt),      32'd0);
        chk("abort_done0",  32'(done),     32'd0);
        chk("abort_incr0",  32'(cnt_incr), 32'd0);
        chk("abort_shadow", 32'(shadow),   32'd0);
        rst = 1'b0;
        req = 4'b0001; req_cnt = 16'h0001;
        crst_hi = 0; done_seen = 0; gnt_quiet = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (cnt_rst) crst_hi++;
            if (done != 4'd0) done_seen++;
            if (gnt != 4'd0) gnt_quiet = 1'b0;
            tick();
        end
        chk("abort_cnt_rst_len", 32'(crst_hi),   32'd2);
        chk("abort_no_done",     32'(done_seen), 32'd0);
        chk("abort_gnt_quiet",   32'(gnt_quiet), 32'd1);
        chk("first_grant_c5",    32'(gnt),       32'b0001);
        req = 4'd0;
        len = 0;
        while (gnt != 4'd0 && len < 50) begin len++; tick(); end
        chk("abort_after_shadow", 32'(shadow),   32'd1);
        chk("abort_after_grey",   32'(cnt_grey), 32'b000001);
        chk("abort_after_err",    32'(err),      32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
